// File: rtl/serial_frame_tx_pkg.sv
// rtl/serial_frame_tx_pkg.sv - shared DAQ link widths, FSM encoding and Gray helper
package serial_frame_tx_pkg;

    localparam int WORD_W = 16;
    localparam int GRAY_W = 12;
    localparam int TAG_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Same definition as the receive-side decoder's inverse.
    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/serial_frame_tx_bin_to_gray.sv
// rtl/serial_frame_tx_bin_to_gray.sv - combinational binary to Gray encoder
module bin_to_gray
    import serial_frame_tx_pkg::*;
#(
    parameter int N = GRAY_W
) (
    input  logic [N-1:0] bin_i,
    output logic [N-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - buffered word-to-serial frame transmitter with Gray-coded value field
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int MIN_GAP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_last,
    output logic              ser_dout,
    output logic              ser_en,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    localparam int GAP_W = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  hold_data_q;
    logic               hold_last_q;
    logic               hold_full_q, hold_full_d;
    logic [WORD_W-1:0]  shift_q, shift_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               cur_last_q, cur_last_d;
    logic               short_q, short_d;
    logic               load;
    logic               accept;
    logic [GRAY_W-1:0]  gray_w;

    logic ser_dout_q, ser_en_q, busy_q, frame_done_q, underrun_q;

    bin_to_gray #(.N(GRAY_W)) u_bin_to_gray (
        .bin_i  (word_data[GRAY_W-1:0]),
        .gray_o (gray_w)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        cur_last_d = cur_last_q;
        short_d    = short_q;
        load       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_d = {shift_q[WORD_W-2:0], 1'b0};
                if (cnt_q == 4'd15) begin
                    if (!cur_last_q && hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                        short_d = ~cur_last_q;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_GAP: begin
                gap_d = gap_q + 1'b1;
                // The IDLE load cycle supplies the last low cycle of the gap.
                if (gap_q == GAP_W'(MIN_GAP - 2)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            shift_d    = hold_data_q;
            cnt_d      = '0;
            cur_last_d = hold_last_q;
        end
    end

    assign word_ready  = ~hold_full_q | load;
    assign accept      = word_valid & word_ready;
    assign hold_full_d = accept | (hold_full_q & ~load);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hold_data_q  <= '0;
            hold_last_q  <= 1'b0;
            hold_full_q  <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= '0;
            gap_q        <= '0;
            cur_last_q   <= 1'b0;
            short_q      <= 1'b0;
            ser_dout_q   <= 1'b0;
            ser_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            if (accept) begin
                hold_data_q <= {word_data[WORD_W-1:GRAY_W], gray_w};
                hold_last_q <= word_last;
            end
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            cur_last_q   <= cur_last_d;
            short_q      <= short_d;
            ser_en_q     <= (state_q == ST_SHIFT);
            ser_dout_q   <= (state_q == ST_SHIFT) & shift_q[WORD_W-1];
            busy_q       <= (state_d != ST_IDLE);
            // First GAP cycle: the last bit has just left the line.
            frame_done_q <= (state_q == ST_GAP) && (gap_q == '0);
            underrun_q   <= (state_q == ST_GAP) && (gap_q == '0) && short_q;
        end
    end

    assign ser_dout   = ser_dout_q;
    assign ser_en     = ser_en_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - scoreboard bench for serial_frame_tx
module tb_serial_frame_tx;

    localparam int MIN_GAP = 4;

    typedef struct {
        logic [15:0] bits;
        bit          end_frame;
        bit          und;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic [15:0] word_data = '0;
    logic        word_last = 1'b0;
    logic        ser_dout, ser_en, busy, frame_done, underrun;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    logic [15:0] acc = '0;
    int nb = 0;
    bit done_due = 0, und_due = 0, seen_frame = 0;
    int low_cnt = 0, last_gap = 0, done_cnt = 0;

    serial_frame_tx #(.MIN_GAP(MIN_GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_last  (word_last),
        .ser_dout   (ser_dout),
        .ser_en     (ser_en),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] w);
        int g;
        g = int'(w[11:0]) ^ (int'(w[11:0]) / 2);
        return {w[15:12], 12'(g)};
    endfunction

    // Monitor: reassemble 16-bit words from the line and check frame markers.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            acc = '0; nb = 0; done_due = 0; und_due = 0; low_cnt = 0;
        end else begin
            if (frame_done || done_due) chk("frame_done", {31'd0, frame_done}, {31'd0, done_due});
            if (underrun || und_due)    chk("underrun", {31'd0, underrun}, {31'd0, und_due});
            if (frame_done) done_cnt++;
            done_due = 0;
            und_due  = 0;
            if (ser_en) begin
                if (low_cnt > 0 && seen_frame) begin
                    last_gap = low_cnt;
                    checks++;
                    if (low_cnt < MIN_GAP) begin
                        errors++;
                        $display("FAIL gap_min: got %0d expected >= %0d", low_cnt, MIN_GAP);
                    end
                end
                low_cnt = 0;
                acc = {acc[14:0], ser_dout};
                nb++;
                if (nb == 16) begin
                    nb = 0;
                    seen_frame = 1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", {16'd0, acc}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_bits", {16'd0, acc}, {16'd0, e.bits});
                        done_due = e.end_frame;
                        und_due  = e.und;
                    end
                end
            end else begin
                low_cnt++;
            end
        end
    end

    task automatic send(input logic [15:0] d, input bit last, input bit und);
        exp_t e;
        int n = 0;
        word_valid = 1'b1;
        word_data  = d;
        word_last  = last;
        while (!word_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("send_timeout", 32'd1, 32'd0);
            word_valid = 1'b0;
        end else begin
            @(posedge clk);
            e.bits = model(d);
            e.end_frame = last | und;
            e.und = und;
            exp_q.push_back(e);
            #1 word_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (3) @(negedge clk);
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("idle_timeout", 32'd1, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int d0, nw, dly, n;
        logic [15:0] w;
        repeat (2) @(negedge clk);
        chk("rst_ser_dout", {31'd0, ser_dout}, 32'd0);
        chk("rst_ser_en", {31'd0, ser_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        chk("rst_word_ready", {31'd0, word_ready}, 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single word: ser_en rises two edges after acceptance.
        d0 = done_cnt;
        send(16'h1ABC, 1, 0);
        chk("lat_t0", {31'd0, ser_en}, 32'd0);
        @(negedge clk);
        chk("lat_t1", {31'd0, ser_en}, 32'd0);
        @(negedge clk);
        chk("lat_t2", {31'd0, ser_en}, 32'd1);
        wait_idle();
        chk("single_done_cnt", done_cnt - d0, 32'd1);

        // Back-to-back three-word frame.
        d0 = done_cnt;
        send(16'h0000, 0, 0);
        send(16'h0FFF, 0, 0);
        send(16'hF001, 1, 0);
        wait_idle();
        chk("three_done_cnt", done_cnt - d0, 32'd1);

        // Two queued one-word frames: exact minimum gap.
        send(16'h2345, 1, 0);
        send(16'h3456, 1, 0);
        wait_idle();
        chk("gap_exact", last_gap, MIN_GAP);

        // Second word arrives late: underrun closes the first frame.
        d0 = done_cnt;
        send(16'h4567, 0, 1);
        repeat (36) @(negedge clk);
        send(16'h5678, 1, 0);
        wait_idle();
        chk("late_done_cnt", done_cnt - d0, 32'd2);

        // Randomized frames with short stalls between words.
        for (int f = 0; f < 6; f++) begin
            nw = $urandom_range(1, 5);
            for (int i = 0; i < nw; i++) begin
                dly = $urandom_range(0, 3);
                repeat (dly) @(negedge clk);
                w = 16'($urandom);
                send(w, i == nw - 1, 0);
            end
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        chk("rand_queue_empty", exp_q.size(), 32'd0);

        // Reset while bit 7 of a word is on the line, with a word buffered.
        send(16'h6789, 0, 0);
        send(16'h789A, 1, 0);
        n = 0;
        while (!(ser_en && nb == 8) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_bit7", (n < 100) ? 32'd1 : 32'd0, 32'd1);
        d0 = done_cnt;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_ser_en", {31'd0, ser_en}, 32'd0);
        chk("mid_rst_ser_dout", {31'd0, ser_dout}, 32'd0);
        chk("mid_rst_word_ready", {31'd0, word_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("mid_rst_no_done", done_cnt - d0, 32'd0);

        send(16'hABCD, 1, 0);
        wait_idle();
        chk("post_rst_done", done_cnt - d0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
